// File: rtl/quad_decoder_if.sv
// quad_decoder_if: raw encoder inputs and decoded step/dir/err/ready outputs.
interface quad_decoder_if;
    logic enc_a, enc_b, err_clr, step, dir, err, ready;
    modport master (output enc_a, enc_b, err_clr, input step, dir, err, ready);
    modport slave (input enc_a, enc_b, err_clr, output step, dir, err, ready);
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: sync, glitch-filter and Gray-phase decode of A/B into step/dir/err.
// QUAD_X4_EN selects x4 decoding; undefined gives x1 (steps only across the 00/10 boundary).
module quad_decoder #(
    parameter int FILTER_CYCLES = 4
) (
    input logic clk,
    input logic reset,
    quad_decoder_if.slave bus
);
    localparam logic [3:0] HIT = 4'(FILTER_CYCLES - 1);
    localparam logic [4:0] INIT_LAST = 5'(FILTER_CYCLES + 2);
    typedef enum logic {INIT, TRACK} state_t;
    state_t state_q, state_d;
    logic [1:0] sync1_q, sync2_q, filt_q, filt_d, prev_q;
    logic [3:0] cnt_q [2];
    logic [3:0] cnt_d [2];
    logic [4:0] init_q, init_d;
    logic step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic ready, track, fwd, jump, count;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= INIT;
        else state_q <= state_d;

    always_comb state_d = (state_q == INIT && init_q == INIT_LAST) ? TRACK : state_q;

    always_comb ready = state_q == TRACK;

    assign track = state_q == TRACK;
    assign init_d = track ? init_q : init_q + 5'd1;

    // Filter is bypassed in INIT so the phase starts from the live encoder level.
    always_comb
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = (track && sync2_q[i] != filt_q[i] && cnt_q[i] != HIT) ? cnt_q[i] + 4'd1 : 4'd0;
            filt_d[i] = (track && sync2_q[i] != filt_q[i] && cnt_q[i] != HIT) ? filt_q[i] : sync2_q[i];
        end

    assign fwd = filt_q == {prev_q[0], ~prev_q[1]};
    assign jump = (filt_q ^ prev_q) == 2'b11;
`ifdef QUAD_X4_EN
    assign count = filt_q != prev_q && !jump;
`else
    assign count = (prev_q == 2'b10 && filt_q == 2'b00) || (prev_q == 2'b00 && filt_q == 2'b10);
`endif
    assign step_d = track && count;
    assign dir_d = step_d ? fwd : dir_q;
    assign err_d = (track && jump) || (err_q && !bus.err_clr);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q <= '0;
            prev_q <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            init_q <= '0;
            step_q <= 1'b0;
            dir_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            sync1_q <= {bus.enc_a, bus.enc_b};
            sync2_q <= sync1_q;
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            init_q <= init_d;
            step_q <= step_d;
            dir_q <= dir_d;
            err_q <= err_d;
        end

    assign bus.step = step_q;
    assign bus.dir = dir_q;
    assign bus.err = err_q;
    assign bus.ready = ready;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed plus random stimulus against a sample-window reference model.
module tb_quad_decoder;
    localparam int F = 4;
`ifdef QUAD_X4_EN
    localparam bit X4 = 1'b1;
`else
    localparam bit X4 = 1'b0;
`endif
    localparam logic [1:0] SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic clk, reset;
    quad_decoder_if bus ();
    quad_decoder #(.FILTER_CYCLES(F)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int g_steps, g_first, g_dir, s;
    logic [1:0] ph;
    logic [1:0] hist [16384];
    int k;
    logic [1:0] mf, mp;
    logic mstep, mdir, merr, mready;

    function automatic int pos(input logic [1:0] p);
        for (int i = 0; i < 4; i++) if (SEQ[i] == p) return i;
        return 0;
    endfunction

    function automatic int dpos(input logic [1:0] nw, input logic [1:0] od);
        return (pos(nw) - pos(od) + 4) % 4;
    endfunction

    function automatic logic [1:0] fwdnext(input logic [1:0] p);
        return SEQ[(pos(p) + 1) % 4];
    endfunction

    function automatic logic [1:0] revnext(input logic [1:0] p);
        return SEQ[(pos(p) + 3) % 4];
    endfunction

    function automatic logic counted(input logic [1:0] nw, input logic [1:0] od);
        return X4 ? (dpos(nw, od) == 1 || dpos(nw, od) == 3)
                  : ((od == 2'b10 && nw == 2'b00) || (od == 2'b00 && nw == 2'b10));
    endfunction

    function automatic logic [1:0] samp(input int i);
        return i < 1 ? 2'b00 : hist[i];
    endfunction

    // A channel's filtered level follows the synchronized input once its last F samples agree.
    function automatic logic [1:0] win(input int e, input logic [1:0] cur);
        logic [1:0] r, v, t;
        bit same;
        r = cur;
        v = samp(e - 2);
        for (int c = 0; c < 2; c++) begin
            same = 1'b1;
            for (int j = e - F - 1; j <= e - 2; j++) begin
                t = samp(j);
                if (t[c] != v[c]) same = 1'b0;
            end
            if (same) r[c] = v[c];
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset)
        if (!reset) begin
            k <= 0;
            mf <= 2'b00;
            mp <= 2'b00;
            mstep <= 1'b0;
            mdir <= 1'b0;
            merr <= 1'b0;
            mready <= 1'b0;
        end else begin
            k <= k + 1;
            hist[k + 1] <= {bus.enc_a, bus.enc_b};
            mready <= k + 1 >= F + 3;
            mp <= mf;
            mf <= k >= F + 3 ? win(k + 1, mf) : samp(k - 1);
            mstep <= k >= F + 3 && counted(mf, mp);
            mdir <= (k >= F + 3 && counted(mf, mp)) ? dpos(mf, mp) == 1 : mdir;
            merr <= (k >= F + 3 && dpos(mf, mp) == 2) ? 1'b1 : bus.err_clr ? 1'b0 : merr;
        end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("model_step", bus.step, mstep);
        chk("model_dir", bus.dir, mdir);
        chk("model_err", bus.err, merr);
        chk("model_ready", bus.ready, mready);
    endtask

    task automatic go(input logic [1:0] p, input int n);
        ph = p;
        bus.enc_a = p[1];
        bus.enc_b = p[0];
        g_steps = 0;
        g_first = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.step) begin
                g_steps++;
                g_dir = bus.dir;
                if (g_first == 0) g_first = i;
            end
        end
    endtask

    initial begin
        logic [1:0] rev_seq [4];
        logic [1:0] fwd_seq [4];
        rev_seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        fwd_seq = '{2'b10, 2'b00, 2'b01, 2'b11};
        bus.enc_a = 1'b1;
        bus.enc_b = 1'b1;
        bus.err_clr = 1'b0;
        ph = 2'b11;
        reset = 1'b0;
        repeat (2) tick();
        chk("rst_step", bus.step, 0);
        chk("rst_dir", bus.dir, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_ready", bus.ready, 0);
        reset = 1'b1;
        for (int i = 1; i <= F + 3; i++) begin
            tick();
            chk("init_ready", bus.ready, i == F + 3);
            chk("init_step", bus.step, 0);
            chk("init_err", bus.err, 0);
        end
        go(2'b11, 5);
        chk("init_phase_steps", g_steps, 0);
        for (int i = 0; i < 4; i++) begin
            go(rev_seq[i], 10);
            chk("rev_steps", g_steps, (X4 || i == 2) ? 1 : 0);
            if (g_steps != 0) begin
                chk("rev_dir", g_dir, 0);
                chk("rev_latency", g_first, F + 3);
            end
        end
        for (int i = 0; i < 4; i++) begin
            go(fwd_seq[i], 10);
            chk("fwd_steps", g_steps, (X4 || i == 1) ? 1 : 0);
            if (g_steps != 0) begin
                chk("fwd_dir", g_dir, 1);
                chk("fwd_latency", g_first, F + 3);
            end
        end
        go(2'b01, 10);
        go(2'b11, F - 1);
        s = g_steps;
        go(2'b01, 10);
        chk("glitch_short", s + g_steps, 0);
        go(2'b11, F);
        s = g_steps;
        go(2'b01, 12);
        chk("pulse_exact", s + g_steps, X4 ? 2 : 0);
        go(2'b00, 10);
        go(2'b10, 10);
        go(2'b00, 10);
        chk("pre_jump_steps", g_steps, 1);
        chk("pre_jump_dir", g_dir, 1);
        go(2'b11, 10);
        chk("jump_err", bus.err, 1);
        chk("jump_steps", g_steps, 0);
        chk("jump_dir", bus.dir, 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("err_clr", bus.err, 0);
        go(2'b00, F + 2);
        bus.err_clr = 1'b1;
        go(2'b00, 1);
        bus.err_clr = 1'b0;
        chk("set_beats_clr", bus.err, 1);
        go(2'b00, 5);
        chk("err_sticky", bus.err, 1);
        chk("resync_steps", g_steps, 0);
        for (int r = 0; r < 300; r++) begin
            int mv;
            logic [1:0] nx;
            mv = int'($urandom_range(0, 9));
            nx = mv < 4 ? fwdnext(ph) : mv < 8 ? revnext(ph) : mv == 8 ? ~ph : ph;
            bus.err_clr = $urandom_range(0, 7) == 0;
            go(nx, int'($urandom_range(1, 12)));
        end
        bus.err_clr = 1'b0;
        while (ph != 2'b10) go(fwdnext(ph), 10);
        go(2'b00, 10);
        go(2'b11, 10);
        go(2'b10, 10);
        go(2'b00, 4);
        chk("pre_rst_ready", bus.ready, 1);
        chk("pre_rst_err", bus.err, 1);
        chk("pre_rst_dir", bus.dir, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_step", bus.step, 0);
        chk("async_dir", bus.dir, 0);
        chk("async_err", bus.err, 0);
        chk("async_ready", bus.ready, 0);
        repeat (2) tick();
        reset = 1'b1;
        s = 0;
        for (int i = 1; i <= F + 3; i++) begin
            tick();
            chk("reinit_ready", bus.ready, i == F + 3);
            if (bus.step) s++;
        end
        chk("pending_lost", s, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
